// File: rtl/vga_frame_reader.sv
// Display-side reader for the stored frame buffer: generates VGA timing, scans the
// buffer incrementally with replication, and drives the DAC pins one pixel behind the counters.
module vga_frame_reader #(
  parameter int          IMG_W  = 100,
  parameter int          IMG_H  = 100,
  parameter int          SCALE  = 4,
  parameter int          X0     = 120,
  parameter int          Y0     = 40,
  parameter logic [7:0]  BG     = 8'h00,
  parameter int          H_VIS  = 640,
  parameter int          H_FP   = 16,
  parameter int          H_SYNC = 96,
  parameter int          H_BP   = 48,
  parameter int          V_VIS  = 480,
  parameter int          V_FP   = 10,
  parameter int          V_SYNC = 2,
  parameter int          V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_start
);

  localparam logic [9:0]  HLAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  VLAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HVIS     = 10'(H_VIS);
  localparam logic [9:0]  VVIS     = 10'(V_VIS);
  localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0]  X_BEG    = 10'(X0);
  localparam logic [9:0]  X_END    = 10'(X0 + IMG_W * SCALE);
  localparam logic [9:0]  X_LAST   = 10'(X0 + IMG_W * SCALE - 1);
  localparam logic [9:0]  Y_BEG    = 10'(Y0);
  localparam logic [9:0]  Y_END    = 10'(Y0 + IMG_H * SCALE);
  localparam logic [9:0]  Y_LAST   = 10'(Y0 + IMG_H * SCALE - 1);
  localparam logic [2:0]  S_LAST   = 3'(SCALE - 1);
  localparam logic [15:0] ROW_STEP = 16'(IMG_W);

  function automatic logic [23:0] rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction

  logic        pix_en_q, pix_en_d, vga_clk_q, vga_clk_d;
  logic [9:0]  hc_q, hc_d, vc_q, vc_d;
  logic [15:0] addr_q, addr_d, base_q, base_d;
  logic [2:0]  sx_q, sx_d, sy_q, sy_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, fs_q, fs_d;
  logic        in_img, visible, h_wrap, f_wrap;
  logic [23:0] pix;

  assign in_img  = (hc_q >= X_BEG) && (hc_q < X_END) && (vc_q >= Y_BEG) && (vc_q < Y_END);
  assign visible = (hc_q < HVIS) && (vc_q < VVIS);
  assign h_wrap  = (hc_q == HLAST);
  assign f_wrap  = h_wrap && (vc_q == VLAST);

  always_comb begin
    pix_en_d  = ~pix_en_q;
    vga_clk_d = pix_en_q;
    hc_d      = hc_q;
    vc_d      = vc_q;
    addr_d    = addr_q;
    base_d    = base_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_d   = blank_q;
    fs_d      = 1'b0;
    pix       = 24'h0;
    if (pix_en_q) begin
      // Pins show the position held before this tick; its read data has just arrived.
      if (in_img)
        pix = rgb332(rd_data);
      else if (visible)
        pix = rgb332(BG);
      {r_d, g_d, b_d} = pix;
      hsync_d = !((hc_q >= HS_BEG) && (hc_q < HS_END));
      vsync_d = !((vc_q >= VS_BEG) && (vc_q < VS_END));
      blank_d = visible;
      fs_d    = f_wrap;

      hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
      if (h_wrap)
        vc_d = (vc_q == VLAST) ? 10'd0 : vc_q + 10'd1;

      if (f_wrap) begin
        addr_d = 16'd0;
        base_d = 16'd0;
        sx_d   = 3'd0;
        sy_d   = 3'd0;
      end else if (in_img) begin
        if (sx_q == S_LAST) begin
          sx_d = 3'd0;
          // Line end is handled on the last image column so addr never passes the buffer.
          if (hc_q == X_LAST) begin
            if (sy_q == S_LAST) begin
              sy_d = 3'd0;
              if (vc_q != Y_LAST) begin
                base_d = base_q + ROW_STEP;
                addr_d = base_q + ROW_STEP;
              end else begin
                addr_d = base_q;
              end
            end else begin
              sy_d   = sy_q + 3'd1;
              addr_d = base_q;
            end
          end else begin
            addr_d = addr_q + 16'd1;
          end
        end else begin
          sx_d = sx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
      hc_q      <= 10'd0;
      vc_q      <= 10'd0;
      addr_q    <= 16'd0;
      base_q    <= 16'd0;
      sx_q      <= 3'd0;
      sy_q      <= 3'd0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pix_en_q  <= pix_en_d;
      vga_clk_q <= vga_clk_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
    end
  end

  assign rd_addr     = addr_q;
  assign vga_clk     = vga_clk_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a reduced-timing instance checked pixel by pixel against a
// position/arithmetic model, plus a default-timing instance for reset and line-0 behaviour.
module tb_vga_frame_reader;

  localparam int AW = 6, AH = 5, AS = 3, AX = 5, AY = 4;
  localparam int HV = 40, HF = 4, HSY = 8, HB = 8, HT = HV + HF + HSY + HB;
  localparam int VV = 30, VF = 2, VSY = 2, VB = 4, VT = VV + VF + VSY + VB;
  localparam int F  = HT * VT;
  localparam logic [7:0] BGC = 8'hE0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [15:0] rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        vclk_a, hs_a, vs_a, bl_a, fs_a;
  logic        vclk_b, hs_b, vs_b, bl_b, fs_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_frame_reader #(
    .IMG_W(AW), .IMG_H(AH), .SCALE(AS), .X0(AX), .Y0(AY), .BG(BGC),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut_a (
    .clk(clk), .rst(rst_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .vga_clk(vclk_a), .hsync(hs_a), .vsync(vs_a), .blank_n(bl_a),
    .r(r_a), .g(g_a), .b(b_a), .frame_start(fs_a)
  );

  vga_frame_reader #(.BG(8'hE0)) dut_b (
    .clk(clk), .rst(rst_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .vga_clk(vclk_b), .hsync(hs_b), .vsync(vs_b), .blank_n(bl_b),
    .r(r_b), .g(g_b), .b(b_b), .frame_start(fs_b)
  );

  logic [7:0] mem [0:65535];
  always @(posedge clk) rd_data_a <= mem[rd_addr_a];
  always @(posedge clk) rd_data_b <= rd_addr_b[7:0];

  int n_a = 0, n_b = 0;
  always @(posedge clk) begin
    n_a <= rst_a ? 0 : n_a + 1;
    n_b <= rst_b ? 0 : n_b + 1;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [7:0] c);
    int rr, gg, bb;
    rr = int'(c[7:5]);
    gg = int'(c[4:2]);
    bb = int'(c[1:0]);
    return {8'((rr * 255 + 3) / 7), 8'((gg * 255 + 3) / 7), 8'(bb * 85)};
  endfunction

  function automatic logic in_img(input int h, input int v);
    return (h >= AX) && (h < AX + AW * AS) && (v >= AY) && (v < AY + AH * AS);
  endfunction

  function automatic int img_addr(input int h, input int v);
    return ((v - AY) / AS) * AW + (h - AX) / AS;
  endfunction

  function automatic logic [23:0] exp_rgb(input int h, input int v);
    if (in_img(h, v)) return expand(mem[img_addr(h, v)]);
    if (h < HV && v < VV) return expand(BGC);
    return 24'h0;
  endfunction

  logic mon_a = 1'b0;
  int   rd_cnt [AW*AH];
  int   hs_low, vs_low, bl_hi, fs_cnt;

  always @(negedge clk) begin : mon_a_blk
    int p, q, h, v, c, ch, cv;
    if (mon_a) begin
      if (n_a < 2) begin
        chk("a_rst_rgb", {8'h0, r_a, g_a, b_a}, 32'h0);
        chk("a_rst_blank", bl_a, 1'b0);
        chk("a_rst_hsync", hs_a, 1'b1);
        chk("a_rst_vsync", vs_a, 1'b1);
        chk("a_rst_fs", fs_a, 1'b0);
        chk("a_rst_vclk", vclk_a, 1'b0);
        chk("a_rst_addr", rd_addr_a, 32'h0);
        for (int i = 0; i < AW * AH; i++) rd_cnt[i] = 0;
        hs_low = 0; vs_low = 0; bl_hi = 0; fs_cnt = 0;
      end else begin
        p = n_a / 2 - 1;
        q = p % F;
        h = q % HT;
        v = q / HT;
        chk("a_rgb", {8'h0, r_a, g_a, b_a}, {8'h0, exp_rgb(h, v)});
        chk("a_blank", bl_a, (h < HV) && (v < VV));
        chk("a_hsync", hs_a, !((h >= HV + HF) && (h < HV + HF + HSY)));
        chk("a_vsync", vs_a, !((v >= VV + VF) && (v < VV + VF + VSY)));
        chk("a_vclk", vclk_a, (n_a % 2) == 0);
        chk("a_frame_start", fs_a, ((n_a % 2) == 0) && (((n_a / 2) % F) == 0));
        c  = (n_a / 2) % F;
        ch = c % HT;
        cv = c / HT;
        if (in_img(ch, cv)) begin
          chk("a_rd_addr", rd_addr_a, img_addr(ch, cv));
          if ((n_a % 2) == 0) rd_cnt[img_addr(ch, cv)]++;
        end
        chk("a_addr_bound", rd_addr_a <= 16'(AW * AH - 1), 1'b1);
        if ((n_a % 2) == 0) begin
          hs_low += int'(!hs_a);
          vs_low += int'(!vs_a);
          bl_hi  += int'(bl_a);
          fs_cnt += int'(fs_a);
          if (((n_a / 2) % F) == 0) begin
            for (int i = 0; i < AW * AH; i++) chk("a_reads_per_addr", rd_cnt[i], AS * AS);
            chk("a_frame_hsync_low", hs_low, HSY * VT);
            chk("a_frame_vsync_low", vs_low, VSY * HT);
            chk("a_frame_blank_hi", bl_hi, HV * VV);
            chk("a_frame_fs_count", fs_cnt, 1);
            for (int i = 0; i < AW * AH; i++) rd_cnt[i] = 0;
            hs_low = 0; vs_low = 0; bl_hi = 0; fs_cnt = 0;
          end
        end
      end
    end
  end

  task automatic wait_n(input bit sel_b, input int target, input string nm);
    int g;
    g = 0;
    while ((sel_b ? n_b : n_a) < target && g < 100000) begin
      @(negedge clk);
      g++;
    end
    chk(nm, sel_b ? n_b : n_a, target);
  endtask

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
    logic        bl;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t tv [12];

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      wait_n(1'b0, 2 * (tv[i].v * HT + tv[i].h + 1), "tab_reach");
      chk($sformatf("tab%0d_rgb", i), {8'h0, r_a, g_a, b_a}, {8'h0, tv[i].rgb});
      chk($sformatf("tab%0d_blank", i), bl_a, tv[i].bl);
      chk($sformatf("tab%0d_hsync", i), hs_a, tv[i].hs);
      chk($sformatf("tab%0d_vsync", i), vs_a, tv[i].vs);
    end
  endtask

  initial begin
    int hr, nf;
    logic prev;
    tv[0]  = '{4,  4,  24'hFF0000, 1'b1, 1'b1, 1'b1};
    tv[1]  = '{5,  4,  24'h000000, 1'b1, 1'b1, 1'b1};
    tv[2]  = '{8,  4,  24'h000055, 1'b1, 1'b1, 1'b1};
    tv[3]  = '{23, 4,  24'hFF0000, 1'b1, 1'b1, 1'b1};
    tv[4]  = '{45, 4,  24'h000000, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{7,  6,  24'h000000, 1'b1, 1'b1, 1'b1};
    tv[6]  = '{5,  7,  24'h0024AA, 1'b1, 1'b1, 1'b1};
    tv[7]  = '{14, 13, 24'h00B655, 1'b1, 1'b1, 1'b1};
    tv[8]  = '{22, 18, 24'h00FF55, 1'b1, 1'b1, 1'b1};
    tv[9]  = '{5,  19, 24'hFF0000, 1'b1, 1'b1, 1'b1};
    tv[10] = '{5,  31, 24'h000000, 1'b0, 1'b1, 1'b1};
    tv[11] = '{10, 32, 24'h000000, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < AW * AH; i++) mem[i] = 8'(i);

    fork
      begin : proc_a
        @(negedge clk); #1;
        mon_a = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_a = 1'b0;
        run_table();
        wait_n(1'b0, 2 * (2 * F + 1), "a_reach_f2");
        #1;
        for (int i = 0; i < AW * AH; i++) mem[i] = 8'($urandom);
        hr = $urandom_range(0, HT - 1);
        wait_n(1'b0, 2 * (3 * F + 10 * HT + hr), "a_reach_mid");
        #1 rst_a = 1'b1;
        for (int i = 0; i < AW * AH; i++) mem[i] = 8'(i);
        @(negedge clk);
        chk("a_mid_rst_addr", rd_addr_a, 32'h0);
        #1 rst_a = 1'b0;
        run_table();
        wait_n(1'b0, 2 * F + 4, "a_reach_end");
      end
      begin : proc_b
        @(negedge clk);
        repeat (2) @(negedge clk);
        #1 rst_b = 1'b0;
        wait_n(1'b1, 2, "b_reach_px0");
        chk("b_px0_rgb", {8'h0, r_b, g_b, b_b}, 32'h00FF0000);
        chk("b_px0_blank", bl_b, 1'b1);
        wait_n(1'b1, 700, "b_reach_rst");
        #1 rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("b_rst_rgb", {8'h0, r_b, g_b, b_b}, 32'h0);
          chk("b_rst_sync", {hs_b, vs_b, bl_b, fs_b, vclk_b}, 5'b11000);
          chk("b_rst_addr", rd_addr_b, 32'h0);
        end
        #1 rst_b = 1'b0;
        prev = hs_b;
        nf = -1;
        for (int i = 0; i < 3000 && nf < 0; i++) begin
          @(negedge clk);
          if (prev && !hs_b) nf = n_b;
          prev = hs_b;
        end
        chk("b_hsync_fall_clk", (nf >= 1312 && nf <= 1314) ? 32'd1313 : nf, 32'd1313);
        wait_n(1'b1, 2 * (700 + 1), "b_reach_700");
        chk("b_blank_rgb", {8'h0, r_b, g_b, b_b}, 32'h0);
        chk("b_blank_px", bl_b, 1'b0);
        wait_n(1'b1, 2 * (751 + 1), "b_reach_751");
        chk("b_hsync_last_low", hs_b, 1'b0);
        wait_n(1'b1, 2 * (752 + 1), "b_reach_752");
        chk("b_hsync_end", hs_b, 1'b1);
        wait_n(1'b1, 2 * (800 + 300 + 1), "b_reach_line1");
        chk("b_bg_rgb", {8'h0, r_b, g_b, b_b}, 32'h00FF0000);
        chk("b_bg_blank", bl_b, 1'b1);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
